reg_file_sb: RTL and testbench

- Parametrised register file: DEPTH x DATA_WIDTH, one synchronous write port, two asynchronous read ports.
- Adds a per-register busy scoreboard. An issuing instruction reserves its destination register; the eventual write releases it.
- Read ports report data validity and can forward (bypass) same-cycle write data.
- Sits between the decode and execute stages of the next-generation processor datapath. Replaces the fixed 8x8 file.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_rdport.sv | 42 ++++
 rtl/reg_file_sb.sv | 116 +++++++++++
 tb/tb_reg_file_sb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  // Index of the register that may be hardwired to zero.
  localparam int REG_ZERO_IDX = 0;

  // Number of registers addressable with addr_width bits.
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One asynchronous read port: register mux, write bypass and valid flag.
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0]            regs [depth_of(ADDR_WIDTH)],
  input  logic [depth_of(ADDR_WIDTH)-1:0]  busy,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO_IDX);

  logic zero_hit;
  logic byp_hit;

  assign zero_hit = (ZERO_REG != 0) && (rd_addr == ZERO_ADDR);
  // The hardwired zero register must never pick up forwarded data.
  assign byp_hit  = (BYPASS != 0) && wr_en && (wr_addr == rd_addr) && !zero_hit;

  // Priority: hardwired zero, then forwarded write, then stored state.
  always_comb begin
    rd_data  = regs[rd_addr];
    rd_valid = !busy[rd_addr];
    if (zero_hit) begin
      rd_data  = '0;
      rd_valid = 1'b1;
    end else if (byp_hit) begin
      rd_data  = wr_data;
      rd_valid = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard, one write port and two
// combinational read ports with optional same-cycle write forwarding.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [DATA_WIDTH-1:0]            IN,
  input  logic [ADDR_WIDTH-1:0]            INADDRESS,
  input  logic                             WRITE,
  input  logic [ADDR_WIDTH-1:0]            OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0]            OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0]            OUT1,
  output logic [DATA_WIDTH-1:0]            OUT2,
  output logic                             OUT1VALID,
  output logic                             OUT2VALID,
  input  logic                             RESERVE,
  input  logic [ADDR_WIDTH-1:0]            RESADDRESS,
  output logic                             RES_ACCEPT,
  output logic [depth_of(ADDR_WIDTH)-1:0]  BUSY
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO_IDX);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;

  logic zero_wr;
  logic zero_res;
  logic wr_en;
  logic res_accept;

  assign zero_wr  = (ZERO_REG != 0) && (INADDRESS == ZERO_ADDR);
  assign zero_res = (ZERO_REG != 0) && (RESADDRESS == ZERO_ADDR);
  assign wr_en    = WRITE && !zero_wr;

  // A busy register can still be re-reserved when its producer writes it in
  // the same cycle, so back-to-back producers do not stall.
  assign res_accept = RESERVE && !RESET && !zero_res &&
                      (!busy_q[RESADDRESS] || (WRITE && (INADDRESS == RESADDRESS)));

  // Next state: write releases its register, an accepted reservation sets the
  // busy bit afterwards so it wins on a same-address collision.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[INADDRESS] = IN;
      busy_d[INADDRESS] = 1'b0;
    end
    if (res_accept) begin
      busy_d[RESADDRESS] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_d[ZERO_ADDR] = '0;
      busy_d[ZERO_ADDR] = 1'b0;
    end
  end

  // Storage and scoreboard update; reset clears both and beats any request.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign RES_ACCEPT = res_accept;
  assign BUSY       = busy_q;

  reg_file_rdport #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_rd1 (
    .rd_addr  (OUT1ADDRESS),
    .regs     (regs_q),
    .busy     (busy_q),
    .wr_en    (WRITE),
    .wr_addr  (INADDRESS),
    .wr_data  (IN),
    .rd_data  (OUT1),
    .rd_valid (OUT1VALID)
  );

  reg_file_rdport #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_rd2 (
    .rd_addr  (OUT2ADDRESS),
    .regs     (regs_q),
    .busy     (busy_q),
    .wr_en    (WRITE),
    .wr_addr  (INADDRESS),
    .wr_data  (IN),
    .rd_data  (OUT2),
    .rd_valid (OUT2VALID)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances share stimulus, A (no zero reg,
// bypass on) and B (zero reg on, bypass off). Expectations are queued by the
// stimulus and checked by a monitor on the falling edge.
module tb_reg_file_sb;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic       RESERVE;
  logic [2:0] RESADDRESS;

  logic [7:0] a_out1, a_out2, b_out1, b_out2;
  logic       a_v1, a_v2, b_v1, b_v2;
  logic       a_ra, b_ra;
  logic [7:0] a_busy, b_busy;

  always #5 CLK = ~CLK;

  reg_file_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(a_out1), .OUT2(a_out2), .OUT1VALID(a_v1), .OUT2VALID(a_v2),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .RES_ACCEPT(a_ra), .BUSY(a_busy)
  );

  reg_file_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(b_out1), .OUT2(b_out2), .OUT1VALID(b_v1), .OUT2VALID(b_v2),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .RES_ACCEPT(b_ra), .BUSY(b_busy)
  );

  // Signal selectors for the scoreboard
  localparam int A_O1 = 0, A_O2 = 1, A_V1 = 2, A_V2 = 3, A_RA = 4, A_BUSY = 5;
  localparam int B_O1 = 10, B_O2 = 11, B_V1 = 12, B_V2 = 13, B_RA = 14, B_BUSY = 15;

  typedef struct {
    int          id;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] actual(input int id);
    case (id)
      A_O1:    return {24'd0, a_out1};
      A_O2:    return {24'd0, a_out2};
      A_V1:    return {31'd0, a_v1};
      A_V2:    return {31'd0, a_v2};
      A_RA:    return {31'd0, a_ra};
      A_BUSY:  return {24'd0, a_busy};
      B_O1:    return {24'd0, b_out1};
      B_O2:    return {24'd0, b_out2};
      B_V1:    return {31'd0, b_v1};
      B_V2:    return {31'd0, b_v2};
      B_RA:    return {31'd0, b_ra};
      B_BUSY:  return {24'd0, b_busy};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(input int id, input logic [31:0] val, input string name);
    exp_t e;
    e.id   = id;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so every queued expectation is
  // compared against the settled outputs at the falling edge.
  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = exp_q.pop_front();
      act = actual(e.id);
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.val, $time);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RESET = 1'b0; WRITE = 1'b0; RESERVE = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; IN = 8'h00; INADDRESS = 3'd0; WRITE = 1'b0;
    OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0; RESERVE = 1'b1; RESADDRESS = 3'd1;
    step();
    // Reset held, reservation requested: must be refused
    expect_v(A_RA, 0, "a_ra_in_reset");
    expect_v(B_RA, 0, "b_ra_in_reset");
    step();

    idle();
    expect_v(A_BUSY, 8'h00, "a_busy_after_reset");
    expect_v(B_BUSY, 8'h00, "b_busy_after_reset");
    expect_v(A_O1, 8'h00, "a_r0_after_reset");
    expect_v(A_V1, 1, "a_v1_after_reset");
    expect_v(B_V2, 1, "b_v2_after_reset");

    // Write 2A to R3 while reading R3
    step();
    WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h2A; OUT1ADDRESS = 3'd3;
    expect_v(A_O1, 8'h2A, "a_bypass_r3");
    expect_v(B_O1, 8'h00, "b_nobypass_r3");
    expect_v(B_V1, 1, "b_v1_r3_pre");
    step();
    INADDRESS = 3'd7; IN = 8'hFF; OUT2ADDRESS = 3'd7;
    expect_v(A_O1, 8'h2A, "a_r3_stored");
    expect_v(B_O1, 8'h2A, "b_r3_stored");
    expect_v(A_O2, 8'hFF, "a_bypass_r7");
    expect_v(B_O2, 8'h00, "b_nobypass_r7");
    step();
    idle();
    OUT1ADDRESS = 3'd7; OUT2ADDRESS = 3'd3;
    expect_v(A_O1, 8'hFF, "a_r7");
    expect_v(B_O1, 8'hFF, "b_r7");
    expect_v(A_O2, 8'h2A, "a_r3");
    expect_v(A_V1, 1, "a_v1_r7");
    expect_v(B_V2, 1, "b_v2_r3");
    foreach (exp_q[k]) begin end
    for (int i = 0; i < 8; i++) begin
      if (i != 3 && i != 7) begin
        step();
        OUT1ADDRESS = 3'(i);
        expect_v(A_O1, 8'h00, $sformatf("a_r%0d_zero", i));
        expect_v(B_O1, 8'h00, $sformatf("b_r%0d_zero", i));
      end
    end

    // Reserve R5, then try again while busy, then release by writing 11
    step();
    RESERVE = 1'b1; RESADDRESS = 3'd5; OUT1ADDRESS = 3'd5;
    expect_v(A_RA, 1, "a_res5_accept");
    expect_v(B_RA, 1, "b_res5_accept");
    expect_v(A_V1, 1, "a_v5_before_edge");
    step();
    expect_v(A_BUSY, 8'b0010_0000, "a_busy_r5");
    expect_v(B_BUSY, 8'b0010_0000, "b_busy_r5");
    expect_v(A_V1, 0, "a_v5_busy");
    expect_v(B_V1, 0, "b_v5_busy");
    expect_v(A_RA, 0, "a_res5_refused");
    expect_v(B_RA, 0, "b_res5_refused");
    step();
    RESERVE = 1'b0; WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'h11;
    expect_v(A_O1, 8'h11, "a_bypass_r5");
    expect_v(A_V1, 1, "a_v5_bypass");
    expect_v(B_O1, 8'h00, "b_old_r5");
    expect_v(B_V1, 0, "b_old_v5");
    step();
    idle();
    expect_v(A_BUSY, 8'h00, "a_busy_released");
    expect_v(B_BUSY, 8'h00, "b_busy_released");
    expect_v(A_O1, 8'h11, "a_r5");
    expect_v(B_O1, 8'h11, "b_r5");
    expect_v(B_V1, 1, "b_v5_released");

    // Bypass: R2 holds 05, then write 99 while reading on port 2
    step();
    WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h05;
    step();
    IN = 8'h99; OUT2ADDRESS = 3'd2;
    expect_v(A_O2, 8'h99, "a_bypass_r2");
    expect_v(A_V2, 1, "a_v2_bypass_r2");
    expect_v(B_O2, 8'h05, "b_old_r2");
    expect_v(B_V2, 1, "b_v2_r2");
    step();
    idle();
    expect_v(A_O2, 8'h99, "a_r2");
    expect_v(B_O2, 8'h99, "b_r2");

    // R4 busy, then write and reserve R4 in the same cycle
    step();
    RESERVE = 1'b1; RESADDRESS = 3'd4; OUT1ADDRESS = 3'd4;
    expect_v(A_RA, 1, "a_res4_first");
    step();
    WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h3C;
    expect_v(A_BUSY, 8'h10, "a_busy_r4");
    expect_v(A_RA, 1, "a_res4_with_write");
    expect_v(B_RA, 1, "b_res4_with_write");
    expect_v(A_O1, 8'h3C, "a_bypass_r4");
    expect_v(B_V1, 0, "b_v4_busy");
    step();
    idle();
    expect_v(A_BUSY, 8'h10, "a_busy_r4_kept");
    expect_v(B_BUSY, 8'h10, "b_busy_r4_kept");
    expect_v(A_O1, 8'h3C, "a_r4");
    expect_v(B_O1, 8'h3C, "b_r4");
    expect_v(A_V1, 0, "a_v4_busy");
    step();
    WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h44;
    step();
    idle();
    expect_v(A_BUSY, 8'h00, "a_busy_r4_released");
    expect_v(B_O1, 8'h44, "b_r4_final");

    // Zero register: write 77 to R0 then reserve R0
    step();
    WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'h77; OUT1ADDRESS = 3'd0;
    expect_v(A_O1, 8'h77, "a_bypass_r0");
    expect_v(B_O1, 8'h00, "b_r0_during_write");
    step();
    idle();
    RESERVE = 1'b1; RESADDRESS = 3'd0;
    expect_v(B_RA, 0, "b_res0_refused");
    expect_v(A_RA, 1, "a_res0_accept");
    expect_v(B_O1, 8'h00, "b_r0_reads_zero");
    expect_v(B_V1, 1, "b_v0");
    expect_v(A_O1, 8'h77, "a_r0_stored");
    step();
    idle();
    expect_v(B_BUSY, 8'h00, "b_busy0_held");
    expect_v(A_BUSY, 8'h01, "a_busy0_set");
    expect_v(B_O1, 8'h00, "b_r0_still_zero");
    expect_v(A_V1, 0, "a_v0_busy");

    // Set up R1 and R6 busy with data; different-address write+reserve
    step();
    WRITE = 1'b1; INADDRESS = 3'd6; IN = 8'h66; RESERVE = 1'b1; RESADDRESS = 3'd1;
    expect_v(A_RA, 1, "a_res1_diff_addr");
    step();
    INADDRESS = 3'd1; IN = 8'h12; RESADDRESS = 3'd1;
    expect_v(A_BUSY, 8'h03, "a_busy_r0_r1");
    expect_v(B_BUSY, 8'h02, "b_busy_r1");
    expect_v(B_RA, 1, "b_res1_with_write");
    step();
    WRITE = 1'b0; RESADDRESS = 3'd6; OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd6;
    expect_v(B_RA, 1, "b_res6");
    step();
    idle();
    expect_v(B_BUSY, 8'h42, "b_busy_r1_r6");
    expect_v(A_BUSY, 8'h43, "a_busy_r0_r1_r6");
    expect_v(B_O1, 8'h12, "b_r1");
    expect_v(B_V1, 0, "b_v1_busy");
    expect_v(B_O2, 8'h66, "b_r6");
    expect_v(B_V2, 0, "b_v6_busy");

    // Reset together with write and reserve
    step();
    RESET = 1'b1; WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'hEE;
    RESERVE = 1'b1; RESADDRESS = 3'd3;
    expect_v(A_RA, 0, "a_ra_mid_reset");
    expect_v(B_RA, 0, "b_ra_mid_reset");
    step();
    idle();
    expect_v(A_BUSY, 8'h00, "a_busy_post_reset");
    expect_v(B_BUSY, 8'h00, "b_busy_post_reset");
    for (int i = 0; i < 8; i++) begin
      step();
      OUT1ADDRESS = 3'(i);
      OUT2ADDRESS = 3'(7 - i);
      expect_v(A_O1, 8'h00, $sformatf("a_r%0d_post_reset", i));
      expect_v(B_O1, 8'h00, $sformatf("b_r%0d_post_reset", i));
      expect_v(A_V1, 1, $sformatf("a_v%0d_post_reset", i));
      expect_v(B_V2, 1, $sformatf("b_v%0d_post_reset", 7 - i));
    end
    step();
    step();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded, required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
